// File: rtl/div_share_pkg.sv
// Shared types and constants for the divider-sharing scheduler.
package div_share_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_NREQ    = 4;
    localparam int unsigned DEF_LATENCY = 4 * DEF_WIDTH;

    // Bits needed to hold the wait count LATENCY-1.
    function automatic int unsigned cnt_width(input int unsigned latency);
        return (latency < 2) ? 1 : $clog2(latency);
    endfunction

endpackage

// File: rtl/div_share_rr_arb.sv
// Combinational round-robin arbiter: search starts at the pointer and wraps.
module div_share_rr_arb
    import div_share_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   pointer,
    output logic [NREQ-1:0] grant
);

    logic        w_found;
    int unsigned w_idx;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = (32'(pointer) + k) % NREQ;
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_share_sched.sv
// Schedules NREQ requesters onto one shared multi-cycle divider, one division in flight.
// Optional: define DIV_SHARE_ZERO_CHECK_EN to answer zero divisors locally with resp_err.
module div_share_sched
    import div_share_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned NREQ    = DEF_NREQ,
    parameter int unsigned LATENCY = DEF_LATENCY
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*2*WIDTH-1:0]    req_dividend,
    input  logic [NREQ*WIDTH-1:0]      req_divisor,
    output logic [2*WIDTH-1:0]         div_dividend,
    output logic [WIDTH-1:0]           div_divisor,
    output logic                       div_din_valid,
    input  logic [2*WIDTH-1:0]         div_dout,
    input  logic [WIDTH-1:0]           div_remainder,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NREQ)-1:0]    resp_id,
    output logic [2*WIDTH-1:0]         resp_quotient,
    output logic [WIDTH-1:0]           resp_remainder,
    output logic                       resp_err,
    output logic                       busy
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = cnt_width(LATENCY);

    state_t          r_state, w_next;
    logic [IW-1:0]   r_ptr, r_id, w_win;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_dividend, r_quot, w_sel_dividend;
    logic [WIDTH-1:0] r_divisor, r_rem, w_sel_divisor;
    logic [NREQ-1:0] w_grant;
    logic            w_hs, w_zero;

    div_share_rr_arb #(.NREQ(NREQ), .PW(IW)) u_arb (
        .req     (req_valid),
        .pointer (r_ptr),
        .grant   (w_grant)
    );

    always_comb begin
        w_win = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (w_grant[k]) w_win = IW'(k);
        end
    end

    assign w_hs           = (r_state == S_IDLE) && (|w_grant);
    assign w_sel_dividend = req_dividend[w_win*DW +: DW];
    assign w_sel_divisor  = req_divisor[w_win*WIDTH +: WIDTH];

`ifdef DIV_SHARE_ZERO_CHECK_EN
    logic r_err;
    assign w_zero   = (w_sel_divisor == '0);
    assign resp_err = r_err;
`else
    assign w_zero   = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_hs) w_next = w_zero ? S_RESP : S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_next = S_RESP;
            S_RESP:  if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready     = '0;
        div_din_valid = 1'b0;
        resp_valid    = 1'b0;
        busy          = 1'b1;
        case (r_state)
            S_IDLE: begin
                req_ready = w_grant;
                busy      = 1'b0;
            end
            S_ISSUE: div_din_valid = 1'b1;
            S_RESP:  resp_valid    = 1'b1;
            default: ;
        endcase
    end

    // Operands and id are latched at the grant, so later requester activity is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_id       <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
`ifdef DIV_SHARE_ZERO_CHECK_EN
            r_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (w_hs) begin
                    r_dividend <= w_sel_dividend;
                    r_divisor  <= w_sel_divisor;
                    r_id       <= w_win;
                    r_ptr      <= (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
`ifdef DIV_SHARE_ZERO_CHECK_EN
                    r_err      <= w_zero;
                    if (w_zero) begin
                        r_quot <= '1;
                        r_rem  <= w_sel_dividend[WIDTH-1:0];
                    end
`endif
                end
                S_ISSUE: r_cnt <= CW'(LATENCY - 1);
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_quot <= div_dout;
                        r_rem  <= div_remainder;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_dividend   = r_dividend;
    assign div_divisor    = r_divisor;
    assign resp_id        = r_id;
    assign resp_quotient  = r_quot;
    assign resp_remainder = r_rem;

endmodule

// File: tb/tb_div_share_sched.sv
// Directed bench for div_share_sched with a behavioural LATENCY-cycle divider.
module tb_div_share_sched;

    localparam int W = 4;
    localparam int N = 4;
    localparam int L = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid, req_ready;
    logic [N*2*W-1:0] req_dividend;
    logic [N*W-1:0]   req_divisor;
    logic [2*W-1:0]   div_dividend, div_dout, resp_quotient;
    logic [W-1:0]     div_divisor, div_remainder, resp_remainder;
    logic             div_din_valid, resp_valid, resp_ready, resp_err, busy;
    logic [1:0]       resp_id;

    int checks = 0, errors = 0;
    int din_cnt = 0, rdy_cnt = 0, bad_rdy = 0, rv_cnt = 0;

    logic [7:0] m_q;
    logic [3:0] m_r;
    int         m_cnt = 0;
    logic       m_pend = 1'b0;

    typedef struct {
        int id; int dd; int dv; int q; int r;
    } vec_t;
    vec_t vecs[6];

    div_share_sched #(.WIDTH(W), .NREQ(N), .LATENCY(L)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dividend   (req_dividend),
        .req_divisor    (req_divisor),
        .div_dividend   (div_dividend),
        .div_divisor    (div_divisor),
        .div_din_valid  (div_din_valid),
        .div_dout       (div_dout),
        .div_remainder  (div_remainder),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_quotient  (resp_quotient),
        .resp_remainder (resp_remainder),
        .resp_err       (resp_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Shared divider: result valid LATENCY cycles after the start pulse, garbage before.
    always @(posedge clk) begin
        if (div_din_valid) begin
            m_q    <= (div_divisor == 4'd0) ? 8'hFF : div_dividend / 8'(div_divisor);
            m_r    <= (div_divisor == 4'd0) ? div_dividend[3:0]
                                            : 4'(div_dividend % 8'(div_divisor));
            m_cnt  <= L - 1;
            m_pend <= 1'b1;
        end else if (m_pend && m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end
    assign div_dout      = (m_pend && m_cnt == 0) ? m_q : 8'h5A;
    assign div_remainder = (m_pend && m_cnt == 0) ? m_r : 4'hC;

    always @(posedge clk) begin
        if (div_din_valid) din_cnt++;
        if (resp_valid) rv_cnt++;
        if (req_ready != '0) begin
            rdy_cnt++;
            if (busy || !$onehot(req_ready) || ((req_ready & ~req_valid) != '0)) bad_rdy++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input int dd, input int dv);
        req_dividend[id*8 +: 8] = 8'(dd);
        req_divisor[id*4 +: 4]  = 4'(dv);
        req_valid[id]           = 1'b1;
    endtask

    // Returns at the handshake edge; g = -1 if no grant within the budget.
    task automatic wait_grant(output int g);
        bit done = 1'b0;
        g = -1;
        #1;
        for (int i = 0; i < 60 && !done; i++) begin
            if ((req_ready & req_valid) != '0) begin
                for (int k = 0; k < N; k++) if (req_ready[k]) g = k;
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    // Cycles from the handshake edge until resp_valid is seen; -1 on timeout.
    task automatic wait_resp(output int lat);
        lat = -1;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            @(negedge clk);
            if (resp_valid) lat = c;
        end
    endtask

    task automatic serve(input int exp_id, input int q, input int r, input int err,
                         input int lat, input bit drop);
        int g, l;
        wait_grant(g);
        chk("grant_id", g, exp_id);
        if (drop && g >= 0) begin
            #1;
            req_valid[g]           = 1'b0;
            req_dividend[g*8 +: 8] = 8'hA5;
            req_divisor[g*4 +: 4]  = 4'h3;
        end
        wait_resp(l);
        chk("latency", l, lat);
        chk("resp_id", int'(resp_id), exp_id);
        chk("quotient", int'(resp_quotient), q);
        chk("remainder", int'(resp_remainder), r);
        chk("resp_err", int'(resp_err), err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int din0, rdy0, rv0, g, l;
        vecs[0] = '{id: 2, dd: 100, dv: 7,  q: 14,  r: 2};
        vecs[1] = '{id: 0, dd: 255, dv: 15, q: 17,  r: 0};
        vecs[2] = '{id: 3, dd: 31,  dv: 15, q: 2,   r: 1};
        vecs[3] = '{id: 1, dd: 9,   dv: 3,  q: 3,   r: 0};
        vecs[4] = '{id: 2, dd: 0,   dv: 5,  q: 0,   r: 0};
        vecs[5] = '{id: 0, dd: 199, dv: 13, q: 15,  r: 4};

        rst_n = 1'b0; req_valid = '0; req_dividend = '0; req_divisor = '0; resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", int'({busy, resp_valid, div_din_valid, resp_err, req_ready}), 0);
        chk("rst_data", int'({div_dividend, div_divisor, resp_id, resp_quotient, resp_remainder}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // All four requesters at once: pointer 0 gives order 0,1,2,3.
        set_req(0, 100, 7); set_req(1, 255, 2); set_req(2, 64, 8); set_req(3, 13, 15);
        serve(0, 14, 2, 0, 18, 1);
        serve(1, 127, 1, 0, 18, 1);
        serve(2, 8, 0, 0, 18, 1);
        serve(3, 0, 13, 0, 18, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            din0 = din_cnt; rdy0 = rdy_cnt;
            set_req(vecs[i].id, vecs[i].dd, vecs[i].dv);
            serve(vecs[i].id, vecs[i].q, vecs[i].r, 0, 18, 1);
            chk("din_pulses", din_cnt - din0, 1);
            chk("ready_pulses", rdy_cnt - rdy0, 1);
        end

        // Back-pressure on requester 1, then requesters 0 and 3 compete continuously.
        @(negedge clk);
        resp_ready = 1'b0;
        set_req(1, 50, 6);
        wait_grant(g);
        chk("bp_grant", g, 1);
        #1;
        set_req(0, 77, 5); set_req(3, 240, 11); req_valid[1] = 1'b0;
        wait_resp(l);
        chk("bp_latency", l, 18);
        rdy0 = rdy_cnt;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", int'({resp_valid, resp_id, resp_quotient, resp_remainder}),
                int'({1'b1, 2'd1, 8'd8, 4'd2}));
        end
        chk("bp_no_ready", rdy_cnt - rdy0, 0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_grant_after", int'(req_ready), int'(4'b1000));
        serve(3, 21, 9, 0, 18, 0);
        serve(0, 15, 2, 0, 18, 0);
        serve(3, 21, 9, 0, 18, 0);
        serve(0, 15, 2, 0, 18, 0);
        serve(3, 21, 9, 0, 18, 0);
        req_valid = '0;

        @(negedge clk);
        din0 = din_cnt;
        set_req(1, 200, 0);
`ifdef DIV_SHARE_ZERO_CHECK_EN
        serve(1, 255, 8, 1, 1, 1);
        chk("zero_din", din_cnt - din0, 0);
`else
        serve(1, 255, 8, 0, 18, 1);
        chk("zero_din", din_cnt - din0, 1);
`endif

        // Reset during WAIT: no response, pointer back to 0.
        @(negedge clk);
        set_req(2, 100, 7);
        wait_grant(g);
        chk("mid_grant", g, 2);
        #1;
        req_valid = '0;
        repeat (6) @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", int'({busy, resp_valid, div_din_valid, resp_err, req_ready}), 0);
        chk("mid_rst_data", int'({div_dividend, div_divisor, resp_id, resp_quotient, resp_remainder}), 0);
        rv0 = rv_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("mid_no_resp", rv_cnt - rv0, 0);
        chk("mid_idle", int'(busy), 0);
        set_req(3, 45, 4); set_req(1, 99, 9);
        serve(1, 11, 0, 0, 18, 1);
        serve(3, 11, 1, 0, 18, 1);

        @(negedge clk);
        chk("ready_protocol", bad_rdy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
